// File: rtl/rr_channel_arbiter.sv
// ============================================================================
// Module      : rr_channel_arbiter
// Description : Round-robin merge of NUM_REQ four-phase sender channels onto
//               one four-phase output channel. Optional stall watchdog is
//               compiled in with the ARB_WATCHDOG_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_channel_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         in_req,
    input  logic [NUM_REQ*WIDTH-1:0]   in_data,
    output logic [NUM_REQ-1:0]         in_ack,
    output logic                       out_req,
    output logic [WIDTH-1:0]           out_data,
    input  logic                       out_ack,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       stall_err
);

    localparam int c_idWidth = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_stateNext;
    logic [c_idWidth-1:0]   r_rrPtr;
    logic [c_idWidth-1:0]   w_rrPtrNext;
    logic [c_idWidth-1:0]   r_grantId;
    logic [c_idWidth-1:0]   w_grantIdNext;
    logic [WIDTH-1:0]       r_outData;
    logic [WIDTH-1:0]       w_outDataNext;
    logic                   r_outReq;
    logic                   w_outReqNext;
    logic [NUM_REQ-1:0]     r_inAck;
    logic [NUM_REQ-1:0]     w_inAckNext;

    logic                   w_found;
    logic [c_idWidth-1:0]   w_pick;
    logic [c_idWidth-1:0]   w_candIdx;
    int                     w_cand;

    generate
        if (NUM_REQ < 2 || NUM_REQ > 16 || TIMEOUT < 2) begin : g_paramCheck
            $error("rr_channel_arbiter: NUM_REQ must be 2..16 and TIMEOUT >= 2");
        end
    endgenerate

    // First requesting channel at or above rr_ptr, wrapping past NUM_REQ-1.
    always_comb begin
        w_found   = 1'b0;
        w_pick    = '0;
        w_cand    = 0;
        w_candIdx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = int'(r_rrPtr) + k;
            if (w_cand >= NUM_REQ) begin
                w_cand = w_cand - NUM_REQ;
            end
            w_candIdx = c_idWidth'(w_cand);
            if (!w_found && in_req[w_candIdx]) begin
                w_found = 1'b1;
                w_pick  = w_candIdx;
            end
        end
    end

    always_comb begin
        w_stateNext   = r_state;
        w_rrPtrNext   = r_rrPtr;
        w_grantIdNext = r_grantId;
        w_outDataNext = r_outData;
        w_outReqNext  = r_outReq;
        w_inAckNext   = r_inAck;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_grantIdNext = w_pick;
                    w_outDataNext = in_data[w_pick*WIDTH +: WIDTH];
                    w_outReqNext  = 1'b1;
                    w_stateNext   = SEND;
                end
            end
            SEND: begin
                if (out_ack) begin
                    w_outReqNext           = 1'b0;
                    w_inAckNext            = '0;
                    w_inAckNext[r_grantId] = 1'b1;
                    w_stateNext            = DRAIN;
                end
            end
            DRAIN: begin
                if (!in_req[r_grantId] && !out_ack) begin
                    w_inAckNext = '0;
                    w_rrPtrNext = (r_grantId == c_idWidth'(NUM_REQ - 1)) ? '0
                                                                        : r_grantId + 1'b1;
                    w_stateNext = IDLE;
                end
            end
            default: begin
                w_outReqNext = 1'b0;
                w_inAckNext  = '0;
                w_stateNext  = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rrPtr   <= '0;
            r_grantId <= '0;
            r_outData <= '0;
            r_outReq  <= 1'b0;
            r_inAck   <= '0;
        end else begin
            r_rrPtr   <= w_rrPtrNext;
            r_grantId <= w_grantIdNext;
            r_outData <= w_outDataNext;
            r_outReq  <= w_outReqNext;
            r_inAck   <= w_inAckNext;
        end
    end

`ifdef ARB_WATCHDOG_EN
    localparam int c_cntWidth = $clog2(TIMEOUT + 1);

    logic [c_cntWidth-1:0] r_wdCount;
    logic [c_cntWidth-1:0] w_wdCountNext;
    logic                  r_stallErr;

    // Dwell counter restarts whenever the FSM moves, so it measures one wait.
    always_comb begin
        w_wdCountNext = r_wdCount;
        if (w_stateNext != r_state || r_state == IDLE) begin
            w_wdCountNext = '0;
        end else if (r_wdCount != c_cntWidth'(TIMEOUT)) begin
            w_wdCountNext = r_wdCount + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wdCount  <= '0;
            r_stallErr <= 1'b0;
        end else begin
            r_wdCount  <= w_wdCountNext;
            r_stallErr <= r_stallErr | (w_wdCountNext == c_cntWidth'(TIMEOUT));
        end
    end

    assign stall_err = r_stallErr;
`else
    assign stall_err = 1'b0;
`endif

    assign in_ack   = r_inAck;
    assign out_req  = r_outReq;
    assign out_data = r_outData;
    assign grant_id = r_grantId;
    assign busy     = (r_state != IDLE);

endmodule

`default_nettype wire

// File: doc/rr_channel_arbiter.md
# rr_channel_arbiter

Clocked round-robin arbiter that merges NUM_REQ four-phase (req/ack) sender channels onto one shared four-phase output channel feeding a linear buffer pipeline. It grants one requester at a time, latches that requester's data, and sequences both handshakes (upstream and downstream) to completion before re-arbitrating. An optional watchdog flags a handshake that stalls, which is the usual symptom of a deadlocked pipeline stage.

## Interface
- NUM_REQ, 4, number of requester channels (2..16)
- WIDTH, 8, data width per channel
- TIMEOUT, 64, watchdog stall threshold in cycles (used only with watchdog compiled in; must be ≥2)

- clk  input  1  sole clock, rising-edge
- rst_n  input  1  asynchronous active-low reset
- in_req  input  NUM_REQ  per-requester request; bit i belongs to requester i
- in_data  input  NUM_REQ*WIDTH  requester i data at bits [i*WIDTH +: WIDTH]; stable while in_req[i]=1
- in_ack  output  NUM_REQ  per-requester acknowledge; at most one bit high (one-hot or zero)
- out_req  output  1  request to downstream channel
- out_data  output  WIDTH  latched data of granted requester
- out_ack  input  1  acknowledge from downstream
- grant_id  output  $clog2(NUM_REQ)  index of current/last granted requester
- busy  output  1  high whenever state ≠ IDLE
- stall_err  output  1  sticky watchdog flag; constant 0 when watchdog not compiled

## Operation
- All inputs are synchronous to clk (any synchronization happens outside the block).
- Four-phase protocol on every channel: req↑ (data stable) → ack↑ → req↓ → ack↓.
- Registered state: state, rr_ptr, grant_id, out_data, out_req, in_ack; all outputs come straight from registers.
- FSM states: IDLE, SEND, DRAIN.
- IDLE: if any in_req bit is 1, select the first set bit searching upward from rr_ptr with wrap (rr_ptr, rr_ptr+1, …, NUM_REQ-1, 0, …). Next edge: grant_id←g, out_data←in_data[g], out_req←1, state←SEND. If no in_req bit is set, stay in IDLE.
- SEND: hold out_req=1 and out_data. When out_ack is sampled 1: out_req←0, in_ack[g]←1, state←DRAIN.
- DRAIN: hold in_ack[g]=1. When in_req[g]=0 and out_ack=0 are both sampled: in_ack←0, rr_ptr←(g+1) mod NUM_REQ, state←IDLE.
- in_req changes on non-granted channels are ignored outside IDLE; they wait for the next arbitration.
- If in_req[g] drops in SEND (protocol violation), data is already latched and the transfer continues unchanged.
- out_data changes only when IDLE→SEND is taken.

## Timing
- Reset (asynchronous, immediate): state=IDLE, rr_ptr=0, grant_id=0, out_data=0, out_req=0, in_ack=0, busy=0, stall_err=0, watchdog counter=0. Asserting reset mid-transfer aborts it; no handshake is completed.
- Grant latency: out_req rises 1 cycle after in_req is first sampled high in IDLE.
- in_ack[g] rises 1 cycle after out_ack is sampled high.
- in_ack[g] falls 1 cycle after in_req[g]=0 and out_ack=0 are both sampled.
- Minimum transfer is 3 cycles (IDLE, SEND, DRAIN). Re-arbitration occurs in the IDLE cycle right after DRAIN, so the back-to-back throughput is one transfer per 3 cycles.
- Simultaneous requests: only rr_ptr order decides the grant. A requester that is continuously requesting is granted within NUM_REQ transfers.
- rr_ptr wraps from NUM_REQ-1 to 0.

## Configuration
- ARB_WATCHDOG_EN defined: a saturating counter of width $clog2(TIMEOUT+1) clears on every state change and while in IDLE, and increments each cycle spent in SEND or DRAIN. When the counter reaches TIMEOUT, stall_err←1 and stays set until rst_n. A stall has no effect on the FSM; it keeps waiting.
- ARB_WATCHDOG_EN undefined: no counter logic; stall_err is tied to 0; TIMEOUT is ignored.

## Test plan
- Single requester: after reset, in_req=4'b0100, in_data[2]=8'hA5, downstream acks after 2 cycles → out_req high 1 cycle after the request, out_data=8'hA5, grant_id=2, in_ack=4'b0100 one cycle after out_ack; busy=0 after the release.
- Contention: all four in_req held high, each with a distinct data value, auto-acking downstream → grant order 0,1,2,3,0 and one transfer every 3 cycles.
- Wrap and fairness: rr_ptr=3 after a grant to 2; in_req=4'b1001 → grant 3 first, then 0.
- Slow release: the downstream holds out_ack high 5 extra cycles → in_ack stays high and state stays DRAIN until out_ack=0; out_data stays unchanged throughout.
- Reset mid-transfer: rst_n pulsed low while in SEND → out_req, in_ack, busy, grant_id and out_data all 0 immediately; the next request is granted starting from index 0.
- With ARB_WATCHDOG_EN and TIMEOUT=8: out_ack never asserted → stall_err rises after 8 cycles in SEND and stays high until reset. Without ARB_WATCHDOG_EN, the same stimulus leaves stall_err=0.
